player_anim_ctrl: RTL and testbench

//  Downstream of the player movement block: consumes per-frame player centre X/Y and size.

---
 rtl/dk_pkg.sv | 35 +++
 rtl/anim_step_counter.sv | 33 +++
 rtl/player_anim_ctrl.sv | 163 ++++++++++++++++
 tb/tb_player_anim_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dk_pkg.sv
// dk_pkg: shared types and constants for the player animation controller.
//   anim_state_t  - animation state encoding (STAND/WALK/CLIMB)
//   FRAME_*       - sprite ROM frame indices for the start of each cycle
//   walk_frame()  - maps the 4-step walk phase to its sprite frame (1,2,3,2)
//   abs10()       - magnitude of a 10-bit two's complement delta
package dk_pkg;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLIMB = 2'd2
  } anim_state_t;

  localparam logic [2:0] FRAME_STAND  = 3'd0;
  localparam logic [2:0] FRAME_WALK0  = 3'd1;
  localparam logic [2:0] FRAME_CLIMB0 = 3'd4;

  // Walk cycle goes 1,2,3,2 so the legs swing back rather than snapping to 1.
  function automatic logic [2:0] walk_frame(input logic [1:0] phase);
    logic [2:0] f;
    case (phase)
      2'd0:    f = 3'd1;
      2'd1:    f = 3'd2;
      2'd2:    f = 3'd3;
      default: f = 3'd2;
    endcase
    return f;
  endfunction

  // -512 maps to 512 as an unsigned value, which is still correctly "large".
  function automatic logic [9:0] abs10(input logic [9:0] v);
    return v[9] ? (~v + 10'd1) : v;
  endfunction

endpackage

// File: rtl/anim_step_counter.sv
// anim_step_counter: divides the frame rate down to animation steps.
//   frame_clk  in   frame clock
//   Reset      in   synchronous, active-high
//   clear      in   force the count back to 0 (takes priority over enable)
//   enable     in   advance the count this frame
//   wrap       out  combinational pulse: enabled while the count sits at DIV-1;
//                   the count returns to 0 on the same edge
module anim_step_counter #(
  parameter int DIV = 4
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign wrap = enable && (count == LAST);

  always_ff @(posedge frame_clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/player_anim_ctrl.sv
// player_anim_ctrl: turns per-frame player position into sprite animation.
// Classifies frame-to-frame motion as STAND/WALK/CLIMB, tracks facing, and
// produces the sprite frame index plus the clamped top-left draw origin.
//   frame_clk  in   1   one edge per video frame
//   Reset      in   1   synchronous, active-high
//   PlayerX/Y  in   10  player centre from the movement block
//   PlayerS    in   10  sprite size in pixels
//   SpriteX/Y  out  10  draw origin = centre - size/2, clamped at 0
//   FrameIdx   out  3   0 stand, 1..3 walk, 4..5 climb
//   FaceLeft   out  1   mirror sprite horizontally
//   AnimState  out  2   anim_state_t
module player_anim_ctrl
  import dk_pkg::*;
#(
  parameter int WALK_DIV  = 4,
  parameter int CLIMB_DIV = 6,
  parameter int IDLE_HOLD = 3,
  parameter int MAX_STEP  = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY,
  output logic [2:0] FrameIdx,
  output logic       FaceLeft,
  output logic [1:0] AnimState
);

  localparam int IW = (IDLE_HOLD > 1) ? $clog2(IDLE_HOLD) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_HOLD - 1);

  logic [9:0]    prev_x, prev_y;
  logic [9:0]    dx, dy, half, org_x, org_y;
  logic          teleport, primed;
  anim_state_t   state_q, state_d;
  logic [2:0]    frame_q, frame_d;
  logic          face_q, face_d;
  logic [1:0]    walk_phase_q, walk_phase_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          walk_clr, walk_en, walk_wrap;
  logic          climb_clr, climb_en, climb_wrap;

  // Previous position loads even during Reset so the first primed delta is sane.
  always_ff @(posedge frame_clk) begin
    prev_x <= PlayerX;
    prev_y <= PlayerY;
  end

  assign dx       = PlayerX - prev_x;
  assign dy       = PlayerY - prev_y;
  assign teleport = (abs10(dx) > 10'(MAX_STEP)) || (abs10(dy) > 10'(MAX_STEP));

  assign half  = PlayerS >> 1;
  assign org_x = (PlayerX < half) ? 10'd0 : PlayerX - half;
  assign org_y = (PlayerY < half) ? 10'd0 : PlayerY - half;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    face_d  = face_q;
    if (primed) begin
      if (teleport) begin
        state_d = ST_STAND;
        idle_d  = '0;
      end else if (dx != 10'd0) begin
        state_d = ST_WALK;
        idle_d  = '0;
        face_d  = dx[9];
      end else if (dy != 10'd0) begin
        state_d = ST_CLIMB;
        idle_d  = '0;
      end else if (idle_q == IDLE_LAST) begin
        state_d = ST_STAND;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // Counters only run while continuing in their own state with real motion;
  // idle frames leave them frozen, any other transition zeroes them.
  assign walk_en   = primed && !teleport && (dx != 10'd0) && (state_q == ST_WALK);
  assign climb_en  = primed && !teleport && (dx == 10'd0) && (dy != 10'd0)
                     && (state_q == ST_CLIMB);
  assign walk_clr  = primed && ((state_d != ST_WALK) || (state_q != ST_WALK));
  assign climb_clr = primed && ((state_d != ST_CLIMB) || (state_q != ST_CLIMB));

  anim_step_counter #(.DIV(WALK_DIV)) u_walk_cnt (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (walk_clr),
    .enable    (walk_en),
    .wrap      (walk_wrap)
  );

  anim_step_counter #(.DIV(CLIMB_DIV)) u_climb_cnt (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (climb_clr),
    .enable    (climb_en),
    .wrap      (climb_wrap)
  );

  always_comb begin
    frame_d      = frame_q;
    walk_phase_d = walk_phase_q;
    if (primed) begin
      case (state_d)
        ST_WALK: begin
          if (state_q != ST_WALK) begin
            frame_d      = FRAME_WALK0;
            walk_phase_d = 2'd0;
          end else if (walk_wrap) begin
            walk_phase_d = walk_phase_q + 2'd1;
            frame_d      = walk_frame(walk_phase_d);
          end
        end
        ST_CLIMB: begin
          if (state_q != ST_CLIMB) begin
            frame_d = FRAME_CLIMB0;
          end else if (climb_wrap) begin
            frame_d = (frame_q == FRAME_CLIMB0) ? FRAME_CLIMB0 + 3'd1 : FRAME_CLIMB0;
          end
        end
        default: begin
          frame_d      = FRAME_STAND;
          walk_phase_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_STAND;
      frame_q      <= FRAME_STAND;
      face_q       <= 1'b0;
      idle_q       <= '0;
      walk_phase_q <= 2'd0;
      primed       <= 1'b0;
      SpriteX      <= 10'd0;
      SpriteY      <= 10'd0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      face_q       <= face_d;
      idle_q       <= idle_d;
      walk_phase_q <= walk_phase_d;
      primed       <= 1'b1;
      SpriteX      <= org_x;
      SpriteY      <= org_y;
    end
  end

  assign FrameIdx  = frame_q;
  assign FaceLeft  = face_q;
  assign AnimState = state_q;

endmodule

// File: tb/tb_player_anim_ctrl.sv
// tb_player_anim_ctrl: directed scoreboard bench for player_anim_ctrl.
// Each step drives one frame of input, pushes the expected registered outputs,
// and compares them one time unit after the frame_clk edge.
module tb_player_anim_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] PlayerX = 10'd50;
  logic [9:0] PlayerY = 10'd414;
  logic [9:0] PlayerS = 10'd16;
  logic [9:0] SpriteX, SpriteY;
  logic [2:0] FrameIdx;
  logic       FaceLeft;
  logic [1:0] AnimState;

  typedef struct {
    string      tag;
    logic [9:0] sx;
    logic [9:0] sy;
    logic [2:0] fi;
    logic       fl;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  localparam logic [1:0] STAND = 2'd0, WALK = 2'd1, CLIMB = 2'd2;

  player_anim_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .PlayerX   (PlayerX),
    .PlayerY   (PlayerY),
    .PlayerS   (PlayerS),
    .SpriteX   (SpriteX),
    .SpriteY   (SpriteY),
    .FrameIdx  (FrameIdx),
    .FaceLeft  (FaceLeft),
    .AnimState (AnimState)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic checkOutput();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      assert ({SpriteX, SpriteY, FrameIdx, FaceLeft, AnimState} ===
              {e.sx, e.sy, e.fi, e.fl, e.st})
      else begin
        bad++;
        $error("[TB] FAIL %s: got sx=%0d sy=%0d fi=%0d fl=%0d st=%0d, required sx=%0d sy=%0d fi=%0d fl=%0d st=%0d",
               e.tag, SpriteX, SpriteY, FrameIdx, FaceLeft, AnimState,
               e.sx, e.sy, e.fi, e.fl, e.st);
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [9:0] x, input logic [9:0] y,
                               input logic [1:0] st, input logic [2:0] fi, input logic fl,
                               input logic [9:0] sx, input logic [9:0] sy, input string tag);
    exp_t e;
    Reset   = rst;
    PlayerX = x;
    PlayerY = y;
    e.tag = tag; e.sx = sx; e.sy = sy; e.fi = fi; e.fl = fl; e.st = st;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [2:0] walk_tbl [4];
    logic [9:0] x, y;
    walk_tbl[0] = 3'd1; walk_tbl[1] = 3'd2; walk_tbl[2] = 3'd3; walk_tbl[3] = 3'd2;

    $display("[TB] start");
    applyStimulus(1, 50, 414, STAND, 0, 0, 0, 0, "reset0");
    applyStimulus(1, 50, 414, STAND, 0, 0, 0, 0, "reset1");
    // First released frame moves, but must not enter WALK yet.
    applyStimulus(0, 52, 414, STAND, 0, 0, 44, 406, "primed_hold");

    for (int i = 0; i < 16; i++) begin
      x = 10'(54 + 2 * i);
      applyStimulus(0, x, 414, WALK, walk_tbl[(i / 4) % 4], 0, x - 10'd8, 406, "walk_right");
    end

    applyStimulus(0, 82, 414, WALK, 1, 1, 74, 406, "turn_left");
    applyStimulus(0, 82, 414, WALK, 1, 1, 74, 406, "idle1");
    applyStimulus(0, 82, 414, WALK, 1, 1, 74, 406, "idle2");
    applyStimulus(0, 82, 414, STAND, 0, 1, 74, 406, "idle_decay");

    for (int j = 0; j < 7; j++) begin
      y = 10'(413 - j);
      applyStimulus(0, 82, y, CLIMB, (j < 6) ? 3'd4 : 3'd5, 1, 74, y - 10'd8, "climb");
    end

    applyStimulus(0, 84, 406, WALK, 1, 0, 76, 398, "climb_to_walk");
    applyStimulus(0, 82, 406, WALK, 1, 1, 74, 398, "walk_left");
    applyStimulus(0, 540, 406, STAND, 0, 1, 532, 398, "tele_out");
    applyStimulus(0, 50, 406, STAND, 0, 1, 42, 398, "tele_back");
    applyStimulus(0, 5, 3, STAND, 0, 1, 0, 0, "clamp");
    applyStimulus(0, 8, 3, WALK, 1, 0, 0, 0, "half_exact");
    applyStimulus(0, 12, 3, WALK, 1, 0, 4, 0, "max_step");
    applyStimulus(0, 17, 3, STAND, 0, 0, 9, 0, "over_step");
    applyStimulus(0, 19, 3, WALK, 1, 0, 11, 0, "walk_again");
    applyStimulus(0, 17, 3, WALK, 1, 1, 9, 0, "walk_again_left");
    applyStimulus(1, 19, 3, STAND, 0, 0, 0, 0, "reset_mid_walk");
    applyStimulus(0, 19, 3, STAND, 0, 0, 11, 0, "post_reset_primed");
    applyStimulus(0, 21, 3, WALK, 1, 0, 13, 0, "post_reset_walk");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
